// File: rtl/speed_encoder.sv
// Pushbutton front end for the stepper speed path: debounced up/down presses set a
// target level 1..6, and a rate-limited actual level drives the step period.
module speed_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RAMP_CYCLES     = 5000000,
  parameter int unsigned BASE_PERIOD     = 600000,
  parameter int unsigned PERIOD_W        = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                enable,
  output logic [2:0]          digit,
  output logic [2:0]          cur_digit,
  output logic [PERIOD_W-1:0] step_period,
  output logic                busy
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RP_W = $clog2(RAMP_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(RAMP_CYCLES - 1);

  localparam logic [PERIOD_W-1:0] PER1 = PERIOD_W'(BASE_PERIOD / 1);
  localparam logic [PERIOD_W-1:0] PER2 = PERIOD_W'(BASE_PERIOD / 2);
  localparam logic [PERIOD_W-1:0] PER3 = PERIOD_W'(BASE_PERIOD / 3);
  localparam logic [PERIOD_W-1:0] PER4 = PERIOD_W'(BASE_PERIOD / 4);
  localparam logic [PERIOD_W-1:0] PER5 = PERIOD_W'(BASE_PERIOD / 5);
  localparam logic [PERIOD_W-1:0] PER6 = PERIOD_W'(BASE_PERIOD / 6);

  typedef enum logic {IDLE, RAMP} state_e;

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0]      sync1_q, sync2_q, db_q, db_prev_q, press;
  logic [DB_W-1:0] db_cnt_q [2];

  state_e                state_q;
  logic [RP_W-1:0]       ramp_cnt_q;
  logic [2:0]            digit_q, digit_d, cur_q, cur_step;
  logic [PERIOD_W-1:0]   period_q, period_lut;
  logic                  busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= {btn_down, btn_up};
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            db_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  always_comb begin
    digit_d = digit_q;
    if (enable && press[0] && !press[1] && digit_q != 3'd6)
      digit_d = digit_q + 3'd1;
    else if (enable && press[1] && !press[0] && digit_q != 3'd1)
      digit_d = digit_q - 3'd1;
  end

  always_comb begin
    cur_step = (digit_q > cur_q) ? cur_q + 3'd1 : cur_q - 3'd1;
    case (cur_q)
      3'd1:    period_lut = PER1;
      3'd2:    period_lut = PER2;
      3'd3:    period_lut = PER3;
      3'd4:    period_lut = PER4;
      3'd5:    period_lut = PER5;
      3'd6:    period_lut = PER6;
      default: period_lut = PER1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ramp_cnt_q <= '0;
      digit_q    <= 3'd1;
      cur_q      <= 3'd1;
      period_q   <= PER1;
      busy_q     <= 1'b0;
    end else begin
      digit_q  <= digit_d;
      busy_q   <= (cur_q != digit_q);
      period_q <= period_lut;
      case (state_q)
        IDLE: begin
          ramp_cnt_q <= '0;
          if (cur_q != digit_q) state_q <= RAMP;
        end
        RAMP: begin
          // A target that lands on the current level ends the ramp without a step.
          if (cur_q == digit_q) begin
            state_q    <= IDLE;
            ramp_cnt_q <= '0;
          end else if (ramp_cnt_q == RP_LAST) begin
            ramp_cnt_q <= '0;
            cur_q      <= cur_step;
            if (cur_step == digit_q) state_q <= IDLE;
          end else begin
            ramp_cnt_q <= ramp_cnt_q + RP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign digit       = digit_q;
  assign cur_digit   = cur_q;
  assign step_period = period_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_speed_encoder.sv
// Scoreboard bench for speed_encoder: expected target/actual levels and periods are
// queued when buttons are driven and popped as the outputs change.
module tb_speed_encoder;

  localparam int D    = 4;
  localparam int R    = 8;
  localparam int BASE = 600;
  localparam int PW   = 20;

  logic          clk = 1'b0;
  logic          rst, btn_up, btn_down, enable;
  logic [2:0]    digit, cur_digit;
  logic [PW-1:0] step_period;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  int exp_digit_q[$];
  int exp_cur_q[$];
  int exp_per_q[$];
  int digit_times[$];
  int cur_times[$];

  logic [2:0]    prev_digit, prev_cur;
  logic [PW-1:0] prev_per;
  int            mon_e;

  speed_encoder #(
    .DEBOUNCE_CYCLES(D),
    .RAMP_CYCLES    (R),
    .BASE_PERIOD    (BASE),
    .PERIOD_W       (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .enable     (enable),
    .digit      (digit),
    .cur_digit  (cur_digit),
    .step_period(step_period),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  // Scoreboard: every output change must match the next queued expectation.
  initial forever begin
    @(negedge clk);
    if (rst !== 1'b0) begin
      prev_digit = digit;
      prev_cur   = cur_digit;
      prev_per   = step_period;
    end else begin
      if (digit !== prev_digit) begin
        checks++;
        digit_times.push_back(cycle);
        if (exp_digit_q.size() == 0) begin
          failures++;
          $display("FAIL digit_change: got %0d, required no change from %0d", digit, prev_digit);
        end else begin
          mon_e = exp_digit_q.pop_front();
          if (digit !== 3'(mon_e)) begin
            failures++;
            $display("FAIL digit_value: got %0d, required %0d", digit, mon_e);
          end
        end
      end
      if (cur_digit !== prev_cur) begin
        checks++;
        cur_times.push_back(cycle);
        if (exp_cur_q.size() == 0) begin
          failures++;
          $display("FAIL cur_change: got %0d, required no change from %0d", cur_digit, prev_cur);
        end else begin
          mon_e = exp_cur_q.pop_front();
          if (cur_digit !== 3'(mon_e)) begin
            failures++;
            $display("FAIL cur_value: got %0d, required %0d", cur_digit, mon_e);
          end
        end
      end
      if (step_period !== prev_per) begin
        checks++;
        if (exp_per_q.size() == 0) begin
          failures++;
          $display("FAIL period_change: got %0d, required no change from %0d", step_period, prev_per);
        end else begin
          mon_e = exp_per_q.pop_front();
          if (step_period !== PW'(mon_e)) begin
            failures++;
            $display("FAIL period_value: got %0d, required %0d", step_period, mon_e);
          end
        end
      end
      prev_digit = digit;
      prev_cur   = cur_digit;
      prev_per   = step_period;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void push_level(input int d);
    exp_cur_q.push_back(d);
    exp_per_q.push_back(BASE / d);
  endfunction

  function automatic void flush_queues();
    exp_digit_q.delete();
    exp_cur_q.delete();
    exp_per_q.delete();
    digit_times.delete();
    cur_times.delete();
  endfunction

  task automatic do_reset();
    @(negedge clk);
    flush_queues();
    rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; enable = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic press(input bit up, input bit dn, input int hold, input int gap);
    btn_up = up; btn_down = dn;
    tick(hold);
    btn_up = 1'b0; btn_down = 1'b0;
    tick(gap);
  endtask

  task automatic wait_settle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || exp_digit_q.size() != 0 || exp_cur_q.size() != 0 ||
            exp_per_q.size() != 0) && n < 500) begin
      tick(1);
      n++;
    end
    tick(12);
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL %s_settle: pending digit/cur/period %0d/%0d/%0d busy=%b, required 0/0/0 busy=0",
               name, exp_digit_q.size(), exp_cur_q.size(), exp_per_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    tick(2);
    checks += 4;
    if (digit !== 3'd1) begin failures++; $display("FAIL por_digit: got %0d, required 1", digit); end
    if (cur_digit !== 3'd1) begin failures++; $display("FAIL por_cur: got %0d, required 1", cur_digit); end
    if (step_period !== PW'(600)) begin failures++; $display("FAIL por_period: got %0d, required 600", step_period); end
    if (busy !== 1'b0) begin failures++; $display("FAIL por_busy: got %b, required 0", busy); end
    rst = 1'b0;
    tick(2);
    exp_digit_q.push_back(2);
    push_level(2);
    press(1'b1, 1'b0, 6, 6);
    checks++;
    if (busy !== 1'b1 || digit !== 3'd2) begin
      failures++;
      $display("FAIL ramp_started: got busy=%b digit=%0d, required busy=1 digit=2", busy, digit);
    end
    #2;
    flush_queues();
    rst = 1'b1;
    #1;
    checks += 4;
    if (digit !== 3'd1) begin failures++; $display("FAIL async_digit: got %0d, required 1", digit); end
    if (cur_digit !== 3'd1) begin failures++; $display("FAIL async_cur: got %0d, required 1", cur_digit); end
    if (step_period !== PW'(600)) begin failures++; $display("FAIL async_period: got %0d, required 600", step_period); end
    if (busy !== 1'b0) begin failures++; $display("FAIL async_busy: got %b, required 0", busy); end
    tick(3);
    rst = 1'b0;
    tick(20);
    checks += 4;
    if (digit !== 3'd1) begin failures++; $display("FAIL hold_digit: got %0d, required 1", digit); end
    if (cur_digit !== 3'd1) begin failures++; $display("FAIL hold_cur: got %0d, required 1", cur_digit); end
    if (step_period !== PW'(600)) begin failures++; $display("FAIL hold_period: got %0d, required 600", step_period); end
    if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy: got %b, required 0", busy); end
    // Button held through reset must be re-debounced and count as one press.
    rst = 1'b1; btn_up = 1'b1;
    tick(2);
    exp_digit_q.push_back(2);
    push_level(2);
    rst = 1'b0;
    tick(14);
    btn_up = 1'b0;
    wait_settle("reset_held");
    checks++;
    if (digit !== 3'd2 || cur_digit !== 3'd2) begin
      failures++;
      $display("FAIL reset_held: got digit=%0d cur=%0d, required 2/2", digit, cur_digit);
    end
  endtask

  task automatic test_debounce();
    do_reset();
    press(1'b1, 1'b0, 3, 10);
    checks++;
    if (digit !== 3'd1) begin failures++; $display("FAIL glitch_up: got %0d, required 1", digit); end
    press(1'b0, 1'b1, 3, 10);
    exp_digit_q.push_back(2);
    push_level(2);
    btn_up = 1'b1;
    tick(20);
    checks++;
    if (digit !== 3'd2) begin failures++; $display("FAIL held_up: got %0d, required 2", digit); end
    btn_up = 1'b0;
    wait_settle("debounce");
    checks++;
    if (digit !== 3'd2 || cur_digit !== 3'd2) begin
      failures++;
      $display("FAIL release_up: got digit=%0d cur=%0d, required 2/2", digit, cur_digit);
    end
  endtask

  task automatic test_saturation();
    int lvl = 1;
    int nxt;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      if (k < 7) nxt = (lvl < 6) ? lvl + 1 : 6;
      else       nxt = (lvl > 1) ? lvl - 1 : 1;
      if (nxt != lvl) begin
        exp_digit_q.push_back(nxt);
        push_level(nxt);
      end
      lvl = nxt;
      press(k < 7, k >= 7, 6, 6);
      wait_settle("saturation");
      checks++;
      if (digit !== 3'(lvl) || cur_digit !== 3'(lvl)) begin
        failures++;
        $display("FAIL saturation_%0d: got digit=%0d cur=%0d, required %0d", k, digit, cur_digit, lvl);
      end
    end
  endtask

  task automatic test_ramp();
    do_reset();
    for (int d = 2; d <= 4; d++) begin
      exp_digit_q.push_back(d);
      push_level(d);
    end
    for (int c = 0; c < 24; c++) begin
      btn_up = ((c % 8) < 4);
      tick(1);
    end
    btn_up = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL ramp_busy: got %b, required 1", busy); end
    wait_settle("ramp");
    checks += 4;
    if (cur_times.size() != 3 || digit_times.size() != 3) begin
      failures++;
      $display("FAIL ramp_events: got cur=%0d digit=%0d changes, required 3/3", cur_times.size(), digit_times.size());
    end else begin
      if (cur_times[0] - digit_times[0] != R + 1) begin
        failures++;
        $display("FAIL ramp_latency: got %0d, required %0d", cur_times[0] - digit_times[0], R + 1);
      end
      if (cur_times[1] - cur_times[0] != R || cur_times[2] - cur_times[1] != R) begin
        failures++;
        $display("FAIL ramp_interval: got %0d,%0d, required %0d,%0d",
                 cur_times[1] - cur_times[0], cur_times[2] - cur_times[1], R, R);
      end
    end
    if (cur_digit !== 3'd4 || step_period !== PW'(150)) begin
      failures++;
      $display("FAIL ramp_final: got cur=%0d period=%0d, required 4/150", cur_digit, step_period);
    end
    if (busy !== 1'b0) begin failures++; $display("FAIL ramp_idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_reversal();
    do_reset();
    foreach (exp_digit_q[i]) exp_digit_q.delete();
    exp_digit_q = '{2, 3, 4, 3, 2};
    push_level(2);
    push_level(3);
    push_level(2);
    for (int c = 0; c < 40; c++) begin
      btn_up   = (c < 24) && ((c % 8) < 4);
      btn_down = (c >= 20) && (c < 36) && (((c - 20) % 8) < 4);
      tick(1);
    end
    btn_up = 1'b0; btn_down = 1'b0;
    wait_settle("reversal");
    checks += 2;
    if (digit !== 3'd2 || cur_digit !== 3'd2) begin
      failures++;
      $display("FAIL reversal_level: got digit=%0d cur=%0d, required 2/2", digit, cur_digit);
    end
    if (busy !== 1'b0 || step_period !== PW'(300)) begin
      failures++;
      $display("FAIL reversal_idle: got busy=%b period=%0d, required 0/300", busy, step_period);
    end
  endtask

  task automatic test_simul_enable();
    do_reset();
    for (int d = 2; d <= 3; d++) begin
      exp_digit_q.push_back(d);
      push_level(d);
      press(1'b1, 1'b0, 6, 6);
      wait_settle("simul_setup");
    end
    press(1'b1, 1'b1, 6, 8);
    checks++;
    if (digit !== 3'd3) begin failures++; $display("FAIL simultaneous: got %0d, required 3", digit); end
    exp_digit_q.push_back(4);
    push_level(4);
    press(1'b1, 1'b0, 6, 6);
    enable = 1'b0;
    press(1'b1, 1'b0, 6, 6);
    wait_settle("enable_off");
    checks++;
    if (digit !== 3'd4 || cur_digit !== 3'd4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL enable_off: got digit=%0d cur=%0d busy=%b, required 4/4/0", digit, cur_digit, busy);
    end
    enable = 1'b1;
    tick(4);
    exp_digit_q.push_back(5);
    push_level(5);
    press(1'b1, 1'b0, 6, 6);
    wait_settle("enable_on");
    checks++;
    if (digit !== 3'd5 || step_period !== PW'(120)) begin
      failures++;
      $display("FAIL enable_on: got digit=%0d period=%0d, required 5/120", digit, step_period);
    end
  endtask

  initial begin
    rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; enable = 1'b1;
    test_reset();
    test_debounce();
    test_saturation();
    test_ramp();
    test_reversal();
    test_simul_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
